// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between fetch and data, data-first with a fetch starvation guard.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
  logic                  if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                  d_win, i_win, resp;
  always_comb begin
    d_win       = state_q == IDLE && d_req && !(if_req && starve_q >= 4'(MAX_WAIT));
    i_win       = state_q == IDLE && if_req && !d_win;
    resp        = state_q == WAIT && mem_rvalid;
    state_d     = (d_win || i_win) ? REQ : (state_q == REQ && mem_ready) ? WAIT : resp ? IDLE : state_q;
    owner_d     = d_win ? 1'b1 : i_win ? 1'b0 : owner_q;
    // data only wins against a waiting fetch while below the limit, so this never overshoots
    starve_d    = i_win ? 4'd0 : (d_win && if_req) ? starve_q + 4'd1 : starve_q;
    mem_we_d    = d_win ? d_we : i_win ? 1'b0 : mem_we_q;
    mem_addr_d  = d_win ? d_addr : i_win ? if_addr : mem_addr_q;
    mem_wdata_d = d_win ? d_wdata : mem_wdata_q;
    mem_be_d    = d_win ? d_be : i_win ? '1 : mem_be_q;
    if_rvalid_d = resp && !owner_q;
    d_rvalid_d  = resp && owner_q;
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
    d_rdata_d   = d_rvalid_d ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  // grants are combinational, so they are gated to stay low while reset is held
  assign if_gnt    = i_win & rst_n;
  assign d_gnt     = d_win & rst_n;
  assign mem_req   = state_q == REQ;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model and memory.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 4;
  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;
  int i_gnt_cyc, d_gnt_cyc, i_rv_cyc, d_rv_cyc;
  logic g_i, g_d;
  logic [31:0] mem [logic [31:0]];
  // model: 0 = free, 1 = request presented to memory, 2 = awaiting response
  int          m_phase = 0, m_starve = 0;
  logic        m_owner = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        exp_ir = 1'b0, exp_dr = 1'b0;
  logic [31:0] exp_irdata = '0, exp_drdata = '0;
  string       glog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_starve = 0; exp_ir = 1'b0; exp_dr = 1'b0; exp_irdata = '0; exp_drdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, 32'(mem_be), 0);
  endtask

  // called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic run_cycle();
    logic ei, ed;
    logic [31:0] w;
    mem_rdata = (m_phase == 2 && mem_rvalid && !m_we) ? rd_mem(m_addr) : $urandom;
    ed = m_phase == 0 && d_req && !(if_req && m_starve == MAX_WAIT);
    ei = m_phase == 0 && if_req && !ed;
    #1;
    chk("if_gnt", 32'(if_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
    if (m_phase == 1) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_be", 32'(mem_be), 32'(m_be));
      if (m_owner) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_ir));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_dr));
    chk("if_rdata", if_rdata, exp_irdata);
    chk("d_rdata", d_rdata, exp_drdata);
    g_i = if_gnt; g_d = d_gnt;
    if (if_gnt) i_gnt_cyc = cyc;
    if (d_gnt) d_gnt_cyc = cyc;
    if (if_rvalid) i_rv_cyc = cyc;
    if (d_rvalid) d_rv_cyc = cyc;
    if (if_gnt || d_gnt) glog = {glog, d_gnt ? "D" : "I"};
    @(posedge clk);
    cyc++;
    exp_ir = 1'b0; exp_dr = 1'b0;
    if (ei || ed) begin
      m_phase = 1; m_owner = ed; m_we = ed && d_we;
      m_addr = ed ? d_addr : if_addr; m_wdata = d_wdata; m_be = ed ? d_be : 4'hF;
      if (ei) m_starve = 0;
      else if (if_req && m_starve < MAX_WAIT) m_starve++;
    end else if (m_phase == 1) begin
      if (mem_ready) m_phase = 2;
    end else if (m_phase == 2 && mem_rvalid) begin
      m_phase = 0;
      if (m_we) begin
        w = rd_mem(m_addr);
        for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
        mem[m_addr] = w;
      end
      if (m_owner) begin exp_dr = 1'b1; exp_drdata = mem_rdata; end
      else begin exp_ir = 1'b1; exp_irdata = mem_rdata; end
    end
    @(negedge clk);
  endtask

  task automatic req_grant(input logic is_d);
    int n = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    if (is_d) d_req = 1'b1; else if_req = 1'b1;
    do begin run_cycle(); n++; end while (!(is_d ? g_d : g_i) && n < 20);
    if (!(is_d ? g_d : g_i)) chk("grant_timeout", 0, 1);
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic finish_x(input int rd, input int vd);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    repeat (rd) run_cycle();
    mem_ready = 1'b1; run_cycle(); mem_ready = 1'b0;
    repeat (vd) run_cycle();
    mem_rvalid = 1'b1; run_cycle(); mem_rvalid = 1'b0;
    run_cycle();
  endtask

  task automatic drain();
    int n = 0;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    while ((m_phase != 0 || exp_ir || exp_dr) && n < 20) begin run_cycle(); n++; end
    if (m_phase != 0) chk("drain_timeout", 0, 1);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem[32'h100] = 32'h00500093;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cycle();

    if_addr = 32'h100;
    req_grant(1'b0);
    finish_x(0, 0);
    chk("fetch_latency", 32'(i_rv_cyc - i_gnt_cyc), 3);
    chk("fetch_rdata", if_rdata, 32'h00500093);

    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    req_grant(1'b1);
    finish_x(0, 0);
    chk("store_latency", 32'(d_rv_cyc - d_gnt_cyc), 3);
    d_we = 1'b0; d_wdata = 32'h0;
    req_grant(1'b1);
    finish_x(0, 0);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);

    mem_rvalid = 1'b1; mem_ready = 1'b1;
    run_cycle(); run_cycle();
    mem_rvalid = 1'b0; mem_ready = 1'b0;
    run_cycle();
    chk("spurious_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("spurious_if_rdata", if_rdata, 32'h00500093);

    d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h12345678; d_be = 4'h3;
    if_addr = 32'h104; if_req = 1'b1;
    req_grant(1'b1);
    finish_x(3, 2);
    chk("backpressure_latency", 32'(d_rv_cyc - d_gnt_cyc), 8);
    chk("fetch_grant_with_rvalid", 32'(i_gnt_cyc), 32'(d_rv_cyc));
    if_req = 1'b0;
    finish_x(0, 0);

    glog = "";
    d_we = 1'b0; d_addr = 32'h204; if_addr = 32'h100;
    if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1;
    repeat (40) run_cycle();
    if_req = 1'b0; d_req = 1'b0;
    drain();
    total++;
    assert (glog.substr(0, 9) == "DDDDIDDDDI") passed++;
    else $error("FAIL contention_order observed=%s expected=DDDDIDDDDI", glog);

    d_we = 1'b0; d_addr = 32'h200;
    req_grant(1'b1);
    mem_ready = 1'b1; run_cycle(); mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_in_wait");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; run_cycle();
    mem_rvalid = 1'b0; run_cycle();

    for (int c = 0; c < 1500; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
        d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      run_cycle();
      if (g_i) if_req = 1'b0;
      if (g_d) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory bus between the instruction-fetch requester and the load/store (data) requester of the RV32I core. This is the step toward a unified instruction/data memory. Requests are arbitrated with data-first priority and a starvation guard for fetch, and exactly one transaction is outstanding at a time. The block sits between `instr_fetch`/`mem_data` and the external memory model, and fully sequences each transaction: request, memory accept, response return.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MAX_WAIT`, 4, consecutive lost arbitrations after which fetch is forced to win (1..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction word
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata`/`d_be` until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  byte enables
- `d_gnt`  out  1  one-cycle pulse: data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse: load data / store acknowledge
- `d_rdata`  out  DATA_W  load data (don't-care for stores)
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- `mem_ready`  in  1  memory accepts the request in this cycle
- `mem_rvalid`  in  1  memory response (reads and writes); earliest one cycle after accept
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: `mem_req`=1 until `mem_ready`.
  - WAIT: wait for `mem_rvalid`.
- IDLE transitions:
  - Both requests high, and `starve_cnt` < MAX_WAIT: data wins.
  - Both requests high, and `starve_cnt` == MAX_WAIT: fetch wins.
  - Only one request high: it wins.
- Grant behaviour:
  - The winner's `*_gnt` is asserted combinationally in the IDLE cycle.
  - The winner's fields are latched into the `mem_*` registers and the owner is recorded. For fetch: `mem_we`=0, `mem_be`=all ones.
  - Next state is REQ.
- Starvation counter (`starve_cnt`, 4 bits):
  - +1 when data wins while `if_req`=1.
  - Cleared to 0 when fetch is granted.
  - Saturates at MAX_WAIT.
- REQ: on `mem_ready`=1, go to WAIT. `mem_req` deasserts at the same edge.
- WAIT: on `mem_rvalid`=1:
  - Register `mem_rdata` into the owner's `*_rdata`.
  - Pulse the owner's `*_rvalid` in the next cycle.
  - Go to IDLE.
- Non-owner `*_rdata` holds its last value.
- `mem_rvalid` in IDLE or REQ is ignored. No state change, no output pulse.
- Requests arriving in non-IDLE states wait; no grant is issued.
- A grant can occur in the same cycle as the previous response's `*_rvalid` pulse.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE and `starve_cnt`=0.
  - Every output goes to 0: gnts, rvalids, rdatas, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`.
  - The in-flight transaction is dropped; the memory is reset by the same `rst_n`.

## Timing
- Cycle 0: request in IDLE, `*_gnt`=1.
- Cycle 1: `mem_req`=1. With `mem_ready`=1, WAIT is entered at cycle 2.
- Cycle 2: `mem_rvalid`=1.
- Cycle 3: owner `*_rvalid`=1.
- Minimum request-to-response latency is 3 cycles; maximum throughput is one transaction per 3 cycles.
- Each cycle of `mem_ready`=0 in REQ, or `mem_rvalid`=0 in WAIT, adds one cycle.
- `mem_*` fields are stable for the whole of REQ.

## Test plan
- Fetch only: `if_addr`=0x100, memory ready immediately and returns 0x00500093 one cycle later.
  - Required: `if_gnt` at cycle 0, `mem_req` at cycle 1, `if_rvalid`=1 with `if_rdata`=0x00500093 at cycle 3.
- Store then load: `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF, `d_be`=0xF; then a load from 0x200.
  - Required: store gets `d_rvalid` at cycle 3; load returns `d_rdata`=0xDEADBEEF.
- Contention: `if_req` and `d_req` held high continuously, MAX_WAIT=4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I…
  - Required: `starve_cnt` returns to 0 after each fetch grant.
- Back-pressure: `mem_ready` low for 3 cycles, then `mem_rvalid` delayed 2 cycles.
  - Required: `mem_*` stable during REQ; response at cycle 3+3+2=8.
  - Required: no second grant before the response.
- Reset in WAIT: drop `rst_n` while a data load is outstanding.
  - Required: all outputs 0 immediately (asynchronously); after release, a late `mem_rvalid` produces no `d_rvalid`.
- Spurious response: `mem_rvalid`=1 while in IDLE with no requests.
  - Required: no `*_rvalid` pulse; `*_rdata` unchanged.
